// File: rtl/ame_line_loader.sv
// ame_line_loader: packs a byte-beat stream into DATA_WIDTH-byte rows and
// writes them into the AME line buffer through its horizontal row port.
// A block is ROW_COUNT rows; after a block the loader stalls input until the
// consumer pulses rel_i. s_last_i framing errors are flagged on sticky err_o.
// Optional build macro AME_LINE_LOADER_ZERO_PAD_EN: on an early s_last_i, the
// rows left unfilled are written with zeros before the block is handed over.
module ame_line_loader #(
    parameter int DATA_WIDTH = 128,
    parameter int BEAT_BYTES = 16,
    parameter int ROW_COUNT  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [BEAT_BYTES*8-1:0]       s_data_i,
    input  logic                          s_last_i,
    output logic                          wr_h_en_o,
    output logic [$clog2(DATA_WIDTH)-1:0] wr_h_addr_o,
    output logic [DATA_WIDTH*8-1:0]       wr_h_data_o,
    output logic                          done_o,
    input  logic                          rel_i,
    output logic                          err_o
);
    localparam int BPR = DATA_WIDTH / BEAT_BYTES;
    localparam int AW  = $clog2(DATA_WIDTH);
    localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BPR - 1);
    localparam logic [AW-1:0] LAST_ROW  = AW'(ROW_COUNT - 1);

`ifdef AME_LINE_LOADER_ZERO_PAD_EN
    typedef enum logic [1:0] {FILL, PAD, DONE} state_e;
`else
    typedef enum logic [1:0] {FILL, DONE} state_e;
`endif

    state_e                  state_q, state_d;
    logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [AW-1:0]           row_cnt_q, row_cnt_d;
    logic [DATA_WIDTH*8-1:0] row_buf_q, row_buf_d;
    logic                    s_ready_q, s_ready_d;
    logic                    wr_en_q, wr_en_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH*8-1:0] wr_data_q, wr_data_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    accept;
    logic                    row_end;
    logic                    blk_end;
    logic [DATA_WIDTH*8-1:0] merged;

    assign accept  = s_valid_i && s_ready_q;
    assign row_end = (beat_cnt_q == LAST_BEAT);
    assign blk_end = row_end && (row_cnt_q == LAST_ROW);

    // Current row buffer with the incoming beat dropped into its slot.
    always_comb begin
        merged = row_buf_q;
        for (int k = 0; k < BPR; k++) begin
            if (beat_cnt_q == BW'(k))
                merged[k*BEAT_BYTES*8 +: BEAT_BYTES*8] = s_data_i;
        end
    end

    // Next-state and registered-output logic for the fill/pad/done sequence.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        row_cnt_d  = row_cnt_q;
        row_buf_d  = row_buf_q;
        s_ready_d  = s_ready_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        err_d      = err_q;
        unique case (state_q)
            FILL: begin
                s_ready_d = 1'b1;
                if (accept) begin
                    if (row_end || s_last_i) begin
                        // Row complete (or cut short): publish it; the buffer
                        // restarts at zero so a short row pads with zeros.
                        wr_en_d    = 1'b1;
                        wr_addr_d  = row_cnt_q;
                        wr_data_d  = merged;
                        row_buf_d  = '0;
                        beat_cnt_d = '0;
                        row_cnt_d  = row_cnt_q + 1'b1;
                    end else begin
                        row_buf_d  = merged;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if (blk_end) begin
                        err_d     = err_q | ~s_last_i;
                        s_ready_d = 1'b0;
                        done_d    = 1'b1;
                        row_cnt_d = '0;
                        state_d   = DONE;
                    end else if (s_last_i) begin
                        err_d     = 1'b1;
                        s_ready_d = 1'b0;
`ifdef AME_LINE_LOADER_ZERO_PAD_EN
                        if (row_cnt_q == LAST_ROW) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = PAD;
                        end
`else
                        done_d    = 1'b1;
                        row_cnt_d = '0;
                        state_d   = DONE;
`endif
                    end
                end
            end
`ifdef AME_LINE_LOADER_ZERO_PAD_EN
            PAD: begin
                // One zero row per cycle until the block's last row is written.
                wr_en_d   = 1'b1;
                wr_addr_d = row_cnt_q;
                wr_data_d = '0;
                row_cnt_d = row_cnt_q + 1'b1;
                if (row_cnt_q == LAST_ROW) begin
                    done_d    = 1'b1;
                    row_cnt_d = '0;
                    state_d   = DONE;
                end
            end
`endif
            DONE: begin
                s_ready_d = 1'b0;
                if (rel_i) begin
                    done_d     = 1'b0;
                    s_ready_d  = 1'b1;
                    beat_cnt_d = '0;
                    row_cnt_d  = '0;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State and output registers; reset drops any partial row.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= FILL;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
            row_buf_q  <= '0;
            s_ready_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            row_cnt_q  <= row_cnt_d;
            row_buf_q  <= row_buf_d;
            s_ready_q  <= s_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign s_ready_o   = s_ready_q;
    assign wr_h_en_o   = wr_en_q;
    assign wr_h_addr_o = wr_addr_q;
    assign wr_h_data_o = wr_data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_ame_line_loader.sv
// Bench for ame_line_loader: random beat stream against a block-level model
// that tracks beats-in-block arithmetically and predicts every output.
module tb_ame_line_loader;
    localparam int DW  = 128;
    localparam int BB  = 16;
    localparam int RC  = 16;
    localparam int BPR = DW / BB;
    localparam int AW  = $clog2(DW);
    localparam int BLK = RC * BPR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            s_valid_i = 1'b0;
    logic            s_ready_o;
    logic [BB*8-1:0] s_data_i = '0;
    logic            s_last_i = 1'b0;
    logic            wr_h_en_o;
    logic [AW-1:0]   wr_h_addr_o;
    logic [DW*8-1:0] wr_h_data_o;
    logic            done_o;
    logic            rel_i = 1'b0;
    logic            err_o;

    ame_line_loader #(.DATA_WIDTH(DW), .BEAT_BYTES(BB), .ROW_COUNT(RC)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .s_last_i(s_last_i), .wr_h_en_o(wr_h_en_o), .wr_h_addr_o(wr_h_addr_o),
        .wr_h_data_o(wr_h_data_o), .done_o(done_o), .rel_i(rel_i), .err_o(err_o)
    );

    // model state
    logic            m_ready, m_done, m_err, m_wen;
    logic [AW-1:0]   m_waddr;
    logic [DW*8-1:0] m_wdata, m_buf;
    int              m_n, m_pad, m_padaddr;
    bit              m_acc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [AW-1:0]   log_addr[$];
    logic [DW*8-1:0] log_data[$];
    int              log_cyc[$];
    logic [BB*8-1:0] sent[$];

    task automatic chk1(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ready = 0; m_done = 0; m_err = 0; m_wen = 0;
        m_waddr = '0; m_wdata = '0; m_buf = '0;
        m_n = 0; m_pad = 0; m_padaddr = 0; m_acc = 0;
    endtask

    // Predict outputs after the next rising edge from the block rules.
    task automatic model_step(input bit v, input logic [BB*8-1:0] d, input bit last, input bit rel);
        int r, k;
        m_acc = v && m_ready;
        m_wen = 0;
        if (m_pad > 0) begin
            m_wen = 1; m_waddr = AW'(m_padaddr); m_wdata = '0;
            m_padaddr++; m_pad--;
            if (m_pad == 0) m_done = 1;
        end else if (m_done) begin
            m_ready = 0;
            if (rel) begin m_done = 0; m_ready = 1; m_n = 0; end
        end else begin
            m_ready = 1;
            if (m_acc) begin
                r = m_n / BPR; k = m_n % BPR;
                m_buf[k*BB*8 +: BB*8] = d;
                m_n++;
                if (k == BPR - 1 || last) begin
                    m_wen = 1; m_waddr = AW'(r); m_wdata = m_buf; m_buf = '0;
                end
                if (m_n == BLK) begin
                    if (!last) m_err = 1;
                    m_done = 1; m_ready = 0;
                end else if (last) begin
                    m_err = 1; m_ready = 0;
`ifdef AME_LINE_LOADER_ZERO_PAD_EN
                    m_pad = RC - 1 - r; m_padaddr = r + 1;
                    if (m_pad == 0) m_done = 1;
`else
                    m_done = 1;
`endif
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk1("s_ready", 64'(s_ready_o), 64'(m_ready));
        chk1("done", 64'(done_o), 64'(m_done));
        chk1("err", 64'(err_o), 64'(m_err));
        chk1("wr_en", 64'(wr_h_en_o), 64'(m_wen));
        chk1("wr_addr", 64'(wr_h_addr_o), 64'(m_waddr));
        checks++;
        if (wr_h_data_o !== m_wdata) begin
            errors++;
            for (int b = 0; b < DW; b++) begin
                if (wr_h_data_o[b*8 +: 8] !== m_wdata[b*8 +: 8]) begin
                    $display("FAIL wr_data byte %0d got %0h exp %0h (cycle %0d)",
                             b, wr_h_data_o[b*8 +: 8], m_wdata[b*8 +: 8], cyc);
                    break;
                end
            end
        end
        if (wr_h_en_o === 1'b1) begin
            log_addr.push_back(wr_h_addr_o);
            log_data.push_back(wr_h_data_o);
            log_cyc.push_back(cyc);
        end
    endtask

    task automatic cycle(input bit v, input logic [BB*8-1:0] d, input bit last, input bit rel);
        @(negedge clk);
        cyc++;
        check_outputs();
        s_valid_i = v; s_data_i = d; s_last_i = last; rel_i = rel;
        model_step(v, d, last, rel);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        check_outputs();
        rst_n = 0;
        s_valid_i = 0; s_data_i = '0; s_last_i = 0; rel_i = 0;
        model_reset();
        @(negedge clk);
        cyc++;
        check_outputs();
        chk1("rst_ready", 64'(s_ready_o), 64'd0);
        chk1("rst_wr_en", 64'(wr_h_en_o), 64'd0);
        chk1("rst_done", 64'(done_o), 64'd0);
        chk1("rst_err", 64'(err_o), 64'd0);
        chk1("rst_data_nz", 64'(|wr_h_data_o), 64'd0);
        rst_n = 1;
        model_step(0, '0, 0, 0);
    endtask

    function automatic logic [BB*8-1:0] rnd_beat();
        logic [BB*8-1:0] x;
        for (int i = 0; i < BB / 4; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    // Push nb beats (last on index last_at, -1 for none) with random gaps.
    task automatic send_block(input int nb, input int last_at, input int gap,
                              input bit idx_data, input bit rel_noise);
        logic [BB*8-1:0] d;
        logic [7:0] bb;
        bit v, rel;
        int tries;
        sent.delete();
        for (int b = 0; b < nb; b++) begin
            tries = 0;
            do begin
                v = ($urandom_range(99) >= gap);
                bb = 8'(b);
                d = idx_data ? {BB{bb}} : rnd_beat();
                rel = rel_noise && ($urandom_range(9) == 0);
                cycle(v, d, (b == last_at), rel);
                tries++;
            end while (!m_acc && tries < 64);
            if (!m_acc) begin
                checks++; errors++;
                $display("FAIL beat_timeout beat %0d ready %0b (cycle %0d)", b, s_ready_o, cyc);
                return;
            end
            sent.push_back(d);
        end
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_cyc.delete();
    endtask

    initial begin
        logic [DW*8-1:0] row;
        model_reset();
        do_reset();

        // Block of index-valued beats, no gaps.
        clear_log();
        send_block(BLK, BLK - 1, 0, 1, 0);
        idle(3);
        chk1("t1_nwrites", 64'(log_addr.size()), 64'd16);
        for (int r = 0; r < log_addr.size(); r++) begin
            chk1("t1_addr", 64'(log_addr[r]), 64'(r));
            for (int k = 0; k < BPR; k++)
                chk1("t1_byte", 64'(log_data[r][16*k*8 +: 8]), 64'(8*r + k));
            if (r > 0) chk1("t1_spacing", 64'(log_cyc[r] - log_cyc[r-1]), 64'd8);
        end
        chk1("t1_done", 64'(done_o), 64'd1);
        chk1("t1_err", 64'(err_o), 64'd0);

        // Valid held in DONE; release with a coincident valid.
        for (int i = 0; i < 10; i++) cycle(1, rnd_beat(), 0, 0);
        chk1("t2_ready_held", 64'(s_ready_o), 64'd0);
        cycle(1, rnd_beat(), 0, 1);
        idle(1);
        chk1("t2_done_clr", 64'(done_o), 64'd0);
        chk1("t2_ready_set", 64'(s_ready_o), 64'd1);

        // Random data, random gaps, stray rel_i during fill.
        clear_log();
        send_block(BLK, BLK - 1, 30, 0, 1);
        idle(3);
        chk1("t3_nwrites", 64'(log_addr.size()), 64'd16);
        for (int k = 0; k < BPR; k++) row[k*BB*8 +: BB*8] = sent[k];
        if (log_addr.size() > 0) begin
            chk1("t3_addr0", 64'(log_addr[0]), 64'd0);
            chk1("t3_row0", 64'(log_data[0] == row), 64'd1);
        end
        cycle(0, '0, 0, 1);
        idle(2);

        // Early s_last on beat 19.
        clear_log();
        send_block(20, 19, 20, 0, 0);
        idle(20);
`ifdef AME_LINE_LOADER_ZERO_PAD_EN
        chk1("t4_nwrites", 64'(log_addr.size()), 64'd16);
`else
        chk1("t4_nwrites", 64'(log_addr.size()), 64'd3);
`endif
        if (log_addr.size() > 2) begin
            chk1("t4_addr2", 64'(log_addr[2]), 64'd2);
            chk1("t4_tail_zero", 64'(|log_data[2][DW*8-1:64*8]), 64'd0);
            chk1("t4_beat19", 64'(log_data[2][48*8 +: BB*8] == sent[19]), 64'd1);
        end
        chk1("t4_err", 64'(err_o), 64'd1);
        chk1("t4_done", 64'(done_o), 64'd1);

        // Missing s_last on the final beat.
        do_reset();
        clear_log();
        send_block(BLK, -1, 10, 0, 0);
        idle(3);
        chk1("t5_nwrites", 64'(log_addr.size()), 64'd16);
        chk1("t5_err", 64'(err_o), 64'd1);
        chk1("t5_done", 64'(done_o), 64'd1);

        // Reset after 5 beats, then a clean block.
        do_reset();
        send_block(5, -1, 0, 0, 0);
        do_reset();
        clear_log();
        send_block(BLK, BLK - 1, 25, 0, 1);
        idle(3);
        for (int k = 0; k < BPR; k++) row[k*BB*8 +: BB*8] = sent[k];
        chk1("t6_nwrites", 64'(log_addr.size()), 64'd16);
        if (log_addr.size() > 0) begin
            chk1("t6_addr0", 64'(log_addr[0]), 64'd0);
            chk1("t6_row0", 64'(log_data[0] == row), 64'd1);
        end
        chk1("t6_err", 64'(err_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
